// File: rtl/vec_mem_responder.sv
// Vector load/store responder: serialises one vector request into per-lane accesses
// on a single-port word memory. Optional per-lane masking under VMEM_LANE_MASK_EN.
module vec_mem_lane_cap #(
    parameter int regSize = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cap_en,
    input  logic               lane_on,
    input  logic [regSize-1:0] din,
    output logic [regSize-1:0] dnext
);
    logic [regSize-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (cap_en) dout_d = lane_on ? din : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) dout_q <= '0;
        else      dout_q <= dout_d;
    end

    // Next value exposed so the final lane can be committed in the same edge it arrives.
    assign dnext = dout_d;
endmodule

module vec_mem_responder #(
    parameter int regSize  = 16,
    parameter int vecSize  = 4,
    parameter int addrBits = 10,
    parameter int memDepth = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [regSize-1:0]              req_addr,
    input  logic [vecSize-1:0][regSize-1:0] req_wdata,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [vecSize-1:0][regSize-1:0] rsp_rdata
`ifdef VMEM_LANE_MASK_EN
    ,
    input  logic [vecSize-1:0]              req_lane_mask
`endif
);
    localparam int CW = $clog2(vecSize + 1);
    localparam int LW = (vecSize > 1) ? $clog2(vecSize) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            write_q, write_d;
    logic [addrBits-1:0]             addr_q, addr_d;
    logic [vecSize-1:0][regSize-1:0] wdata_q, wdata_d;
    logic                            req_ready_q, req_ready_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic                            rsp_write_q, rsp_write_d;
    logic [vecSize-1:0][regSize-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [vecSize-1:0]              lane_mask;

`ifdef VMEM_LANE_MASK_EN
    logic [vecSize-1:0] mask_q, mask_d;
    assign lane_mask = mask_q;
`else
    assign lane_mask = '1;
`endif

    logic [regSize-1:0]              mem [memDepth];
    logic [regSize-1:0]              mem_q;
    logic                            mem_we;
    logic [addrBits-1:0]             lane_addr;
    logic [LW-1:0]                   lane_idx, prev_idx;
    logic                            cap_vld;
    logic [vecSize-1:0]              cap_en;
    logic [vecSize-1:0][regSize-1:0] lane_next;

    assign lane_idx  = cnt_q[LW-1:0];
    assign prev_idx  = lane_idx - LW'(1);
    assign lane_addr = addr_q + addrBits'(cnt_q);
    // In READ, a nonzero count means the previous lane's word is sitting in mem_q.
    assign cap_vld   = (state_q == READ) && (cnt_q != '0);

    generate
        if (regSize > addrBits) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[regSize-1:addrBits];
        end
        for (genvar g = 0; g < vecSize; g++) begin : g_lane
            assign cap_en[g] = cap_vld && (prev_idx == LW'(g));
            vec_mem_lane_cap #(.regSize(regSize)) u_cap (
                .clk     (clk),
                .rst     (rst),
                .cap_en  (cap_en[g]),
                .lane_on (lane_mask[g]),
                .din     (mem_q),
                .dnext   (lane_next[g])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef VMEM_LANE_MASK_EN
        mask_d      = mask_q;
`endif
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    write_d     = req_write;
                    addr_d      = req_addr[addrBits-1:0];
                    wdata_d     = req_wdata;
`ifdef VMEM_LANE_MASK_EN
                    mask_d      = req_lane_mask;
`endif
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
                    state_d     = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                mem_we = lane_mask[lane_idx];
                cnt_d  = cnt_q + CW'(1);
                if (lane_idx == LW'(vecSize - 1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            READ: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(vecSize)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = lane_next;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef VMEM_LANE_MASK_EN
            mask_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef VMEM_LANE_MASK_EN
            mask_q      <= mask_d;
`endif
        end
    end

    // Array is never reset; a write is suppressed on a reset edge so an aborted store stops cleanly.
    always_ff @(posedge clk) begin
        if (mem_we && rst) mem[lane_addr] <= wdata_q[lane_idx];
        mem_q <= mem[lane_addr];
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_vec_mem_responder.sv
// Directed bench for vec_mem_responder: reset, store/load latency, wrap, backpressure,
// mid-store reset and (with VMEM_LANE_MASK_EN) lane masking.
module tb_vec_mem_responder;
    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [15:0]      req_addr;
    logic [3:0][15:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_write;
    logic [3:0][15:0] rsp_rdata;
`ifdef VMEM_LANE_MASK_EN
    logic [3:0]       req_lane_mask;
`endif

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vec_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata)
`ifdef VMEM_LANE_MASK_EN
        ,
        .req_lane_mask (req_lane_mask)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request, checks latency/echo/data; retires the response if asked.
    task automatic txn(input string tag, input logic wr, input logic [15:0] a,
                       input logic [63:0] wd, input logic [3:0] m,
                       input logic [63:0] exp_rd, input logic [63:0] cmp, input bit retire);
        int lat;
        chk({tag, "_rdy"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
`ifdef VMEM_LANE_MASK_EN
        req_lane_mask = m;
`else
        if (m != 4'hF) $display("note: lane mask ignored in this build");
`endif
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), wr ? 64'd5 : 64'd6);
        chk({tag, "_wr"}, 64'(rsp_write), 64'(wr));
        chk({tag, "_data"}, rsp_rdata & cmp, exp_rd & cmp);
        if (retire) begin
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk({tag, "_retire"}, 64'(rsp_valid), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] held;
        rst       = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0;
        req_wdata = '0;
        rsp_ready = 1'b0;
`ifdef VMEM_LANE_MASK_EN
        req_lane_mask = 4'hF;
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rdata", rsp_rdata, 64'd0);
        end
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rel_ready", 64'(req_ready), 64'd1);
        chk("rel_write", 64'(rsp_write), 64'd0);

        txn("st10", 1'b1, 16'h0010, 64'h0004_0003_0002_0001, 4'hF, 64'd0, '1, 1'b1);
        tick();
        txn("ld10", 1'b0, 16'h0010, 64'd0, 4'hF, 64'h0004_0003_0002_0001, '1, 1'b1);
        chk("ld10_hold", rsp_rdata, 64'h0004_0003_0002_0001);
        tick();

        txn("stwrap", 1'b1, 16'd1022, 64'h00D4_00C3_00B2_00A1, 4'hF, 64'd0, '1, 1'b1);
        tick();
        txn("ldwrap0", 1'b0, 16'h0000, 64'd0, 4'hF, 64'h0000_0000_00D4_00C3,
            64'h0000_0000_FFFF_FFFF, 1'b1);
        tick();
        txn("ldhi", 1'b0, 16'hFFFE, 64'd0, 4'hF, 64'h00D4_00C3_00B2_00A1, '1, 1'b1);
        tick();

        txn("ldbp", 1'b0, 16'h0010, 64'd0, 4'hF, 64'h0004_0003_0002_0001, '1, 1'b0);
        held      = 64'h0004_0003_0002_0001;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0040;
        req_wdata = 64'h1111_1111_1111_1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_data", rsp_rdata, held);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        chk("bp_wr", 64'(rsp_write), 64'd0);
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        tick();
        rsp_ready = 1'b0;
        chk("bp_retire", 64'(rsp_valid), 64'd0);
        chk("bp_ready_after", 64'(req_ready), 64'd1);
        chk("bp_data_after", rsp_rdata, held);

        txn("st20", 1'b1, 16'h0020, 64'h0009_0009_0009_0009, 4'hF, 64'd0, '1, 1'b1);
        tick();
        chk("abort_rdy", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 64'h0004_0003_0002_0001;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("abort_valid", 64'(rsp_valid), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_norsp", 64'(rsp_valid), 64'd0);
        end
        txn("ld20", 1'b0, 16'h0020, 64'd0, 4'hF, 64'h0009_0009_0002_0001, '1, 1'b1);
        tick();

`ifdef VMEM_LANE_MASK_EN
        txn("mz30", 1'b1, 16'h0030, 64'd0, 4'hF, 64'd0, '1, 1'b1);
        tick();
        txn("ms30", 1'b1, 16'h0030, 64'h0008_0007_0006_0005, 4'b0101, 64'd0, '1, 1'b1);
        tick();
        txn("ml30f", 1'b0, 16'h0030, 64'd0, 4'hF, 64'h0000_0007_0000_0005, '1, 1'b1);
        tick();
        txn("ml303", 1'b0, 16'h0030, 64'd0, 4'b0011, 64'h0000_0000_0000_0005, '1, 1'b1);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
